// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Optional flush support is enabled by defining MD_CANCEL_EN (adds the cancel input).
module md_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MD_CANCEL_EN
    input  logic             cancel,
`endif
    input  logic             start,
    input  logic [2:0]       MDOP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] shadow_hi_q;
    logic [WIDTH-1:0] shadow_lo_q;

    logic             cancel_hit;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] uquot;
    logic [WIDTH-1:0] urem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_zero;
    logic             div_ovf;
    logic [2*WIDTH-1:0] result;

`ifdef MD_CANCEL_EN
    assign cancel_hit = cancel;
`else
    assign cancel_hit = 1'b0;
`endif

    assign op_signed = (MDOP == OP_MULT) || (MDOP == OP_DIV);
    assign a_neg     = op_signed & A[WIDTH-1];
    assign b_neg     = op_signed & B[WIDTH-1];

    // Extending both operands to 2*WIDTH lets one unsigned multiplier serve mult and multu.
    assign a_ext   = {{WIDTH{a_neg}}, A};
    assign b_ext   = {{WIDTH{b_neg}}, B};
    assign product = a_ext * b_ext;

    // Signed divide works on magnitudes, then fixes signs (quotient toward zero).
    assign abs_a    = a_neg ? (~A + ONE_W) : A;
    assign abs_b    = b_neg ? (~B + ONE_W) : B;
    assign div_zero = (B == '0);
    assign div_ovf  = (MDOP == OP_DIV) && (A == MOST_NEG) && (B == '1);
    assign divisor  = div_zero ? ONE_W : abs_b;
    assign uquot    = abs_a / divisor;
    assign urem     = abs_a % divisor;
    assign quot     = (a_neg ^ b_neg) ? (~uquot + ONE_W) : uquot;
    assign rem      = a_neg ? (~urem + ONE_W) : urem;

    always_comb begin
        result = product;
        if (MDOP == OP_DIV || MDOP == OP_DIVU) begin
            if (div_zero) begin
                result = {A, {WIDTH{1'b1}}};
            end else if (div_ovf) begin
                result = {{WIDTH{1'b0}}, A};
            end else begin
                result = {rem, quot};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            shadow_hi_q <= '0;
            shadow_lo_q <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            HI          <= '0;
            LO          <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        case (MDOP)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                {shadow_hi_q, shadow_lo_q} <= result;
                                count_q <= (MDOP == OP_DIV || MDOP == OP_DIVU) ? DIV_N : MULT_N;
                                busy    <= 1'b1;
                                state_q <= StRun;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    count_q <= count_q - CNT_ONE;
                    if (cancel_hit) begin
                        count_q <= '0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (count_q == CNT_ONE) begin
                        HI      <= shadow_hi_q;
                        LO      <= shadow_lo_q;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: scoreboard of expected {HI,LO} pushed at launch, popped on done.
module tb_md_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   MDOP;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
`ifdef MD_CANCEL_EN
    logic         cancel;
`endif

    always #5 clk = ~clk;

    md_unit #(
        .WIDTH      (W),
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MD_CANCEL_EN
        .cancel(cancel),
`endif
        .start (start),
        .MDOP  (MDOP),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          start_cyc;
    logic [63:0] prev_hilo;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        int                sa;
        int                sb;
        int                q;
        int                r;
        longint            ps;
        longint unsigned   pu;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin
                ps = longint'(sa) * longint'(sb);
                return ps;
            end
            3'd1: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                return pu;
            end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, a};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Drives one start pulse; returns 1 time unit after the start edge.
    task automatic launch(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        prev_hilo = {HI, LO};
        sb_q.push_back('{tag: tag, exp: exp});
        MDOP  = op;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start     = 1'b0;
        MDOP      = 3'd7;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int n);
        bit  ok_hold;
        sb_t e;
        ok_hold = 1'b1;
        while (done !== 1'b1 && (cyc - start_cyc) < 40) begin
            if (busy !== 1'b1 || {HI, LO} !== prev_hilo) ok_hold = 1'b0;
            tick();
        end
        check({tag, "_hold"}, 64'(ok_hold), 64'd1);
        check({tag, "_lat"}, 64'(cyc - start_cyc), 64'(n));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy0"}, 64'(busy), 64'd0);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, {HI, LO}, e.exp);
        end
        tick();
        check({tag, "_done_clr"}, 64'(done), 64'd0);
    endtask

    initial begin
        bit          saw_done;
        logic [2:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b0;
        start = 1'b0;
        MDOP  = 3'd7;
        A     = '0;
        B     = '0;
`ifdef MD_CANCEL_EN
        cancel = 1'b0;
`endif
        #12;
        check("rst_state", {60'd0, busy, done, 2'b00}, 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        reset = 1'b1;
        tick();

        launch("mult_5_m3", 3'd0, 32'd5, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFF1);
        wait_done("mult", MC);
        launch("divu_7_2", 3'd3, 32'd7, 32'd2, {32'd1, 32'd3});
        wait_done("divu", DC);
        launch("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        wait_done("div", DC);
        launch("divu_by0", 3'd3, 32'd9, 32'd0, {32'd9, 32'hFFFFFFFF});
        wait_done("divu0", DC);
        launch("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
        wait_done("divovf", DC);
        launch("div_by0", 3'd2, 32'hFFFFFFF0, 32'd0, {32'hFFFFFFF0, 32'hFFFFFFFF});
        wait_done("div0", DC);
        launch("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        wait_done("multu", MC);
        launch("div_m7_m2", 3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3});
        wait_done("div_nn", DC);

        // Starts during busy (divu, then mthi) must be ignored.
        launch("mult_2_3", 3'd0, 32'd2, 32'd3, {32'd0, 32'd6});
        tick();
        MDOP = 3'd3; A = 32'd8; B = 32'd2; start = 1'b1;
        tick();
        MDOP = 3'd4; A = 32'h55;
        tick();
        start = 1'b0; MDOP = 3'd7;
        wait_done("mult_ign", MC);

        MDOP = 3'd4; A = 32'h55; start = 1'b1;
        tick();
        start = 1'b0; MDOP = 3'd7;
        check("mthi", {HI, LO}, {32'h55, 32'd6});
        check("mthi_flags", {62'd0, busy, done}, 64'd0);
        MDOP = 3'd5; A = 32'hA5A5; start = 1'b1;
        tick();
        MDOP = 3'd6; A = 32'h1234;
        tick();
        MDOP = 3'd7;
        tick();
        start = 1'b0;
        check("mtlo_nop", {HI, LO}, {32'h55, 32'hA5A5});
        check("nop_flags", {62'd0, busy, done}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            op = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i == 3) rb = 32'hFFFFFFF3;
            launch($sformatf("rand%0d_op%0d", i, op), op, ra, rb, ref_md(op, ra, rb));
            wait_done("rand", (op >= 3'd2) ? DC : MC);
        end

        // Async reset on cycle 3 of a divu aborts without a done.
        launch("divu_abort", 3'd3, 32'd100, 32'd7, 64'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        sb_q.delete();
        #3;
        reset    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < DC + 4; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        check("abort_quiet", 64'(saw_done), 64'd0);
        check("abort_hilo_after", {HI, LO}, 64'd0);

`ifdef MD_CANCEL_EN
        MDOP = 3'd4; A = 32'd1; start = 1'b1;
        tick();
        MDOP = 3'd5; A = 32'd2;
        tick();
        start = 1'b0; MDOP = 3'd7;
        launch("mult_cancel", 3'd0, 32'd4, 32'd4, 64'd16);
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_hilo", {HI, LO}, {32'd1, 32'd2});
        sb_q.delete();
        saw_done = 1'b0;
        for (int i = 0; i < MC + 3; i++) begin
            tick();
            if (done !== 1'b0) saw_done = 1'b1;
        end
        check("cancel_no_done", 64'(saw_done), 64'd0);
        cancel = 1'b1;
        launch("mult_3_3_cancel_idle", 3'd0, 32'd3, 32'd3, 64'd9);
        cancel = 1'b0;
        wait_done("cancel_idle", MC);
`endif

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
